uart_alu_ctrl: RTL and testbench

- Sequencer between the UART receiver, the ALU and the UART transmitter.
- Collects three consecutive received bytes (operand A, operand B, opcode) and drives them onto the ALU inputs.
- Captures the ALU result and hands it to the transmitter, then waits for the transmission to finish.
- Inter-byte watchdog aborts a partial frame if the host stalls.

---
 rtl/uart_alu_ctrl.sv | 139 +++++++++++++
 tb/tb_uart_alu_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_ctrl.sv
// Sequencer between the UART receiver, the ALU and the UART transmitter.
// Gathers operand A, operand B and opcode, launches the result, and aborts stalled frames.
module uart_alu_ctrl #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int NB_TIMEOUT     = 24
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_drop
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    WAIT_TX
  } state_t;

  localparam bit WD_ENABLE = (TIMEOUT_CYCLES > 0);
  localparam logic [NB_TIMEOUT-1:0] WD_LIMIT =
    WD_ENABLE ? NB_TIMEOUT'(TIMEOUT_CYCLES - 1) : '0;

  state_t                 state_q;
  logic [NB_DATA-1:0]     aluA_q;
  logic [NB_DATA-1:0]     aluB_q;
  logic [NB_OP-1:0]       aluOp_q;
  logic [NB_DATA-1:0]     txData_q;
  logic                   txStart_q;
  logic                   busy_q;
  logic                   timeout_q;
  logic                   drop_q;
  logic [NB_TIMEOUT-1:0]  wdCnt_q;
  logic [NB_TIMEOUT-1:0]  wdCnt_d;
  logic                   wdExpire;

  // A byte arriving on the limit cycle wins over the watchdog.
  assign wdExpire = WD_ENABLE && !i_rx_valid && (wdCnt_q == WD_LIMIT);
  assign wdCnt_d  = wdCnt_q + NB_TIMEOUT'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= WAIT_A;
      aluA_q    <= '0;
      aluB_q    <= '0;
      aluOp_q   <= '0;
      txData_q  <= '0;
      txStart_q <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      drop_q    <= 1'b0;
      wdCnt_q   <= '0;
    end else begin
      txStart_q <= 1'b0;
      timeout_q <= 1'b0;
      drop_q    <= 1'b0;
      case (state_q)
        WAIT_A: begin
          wdCnt_q <= '0;
          if (i_rx_valid) begin
            aluA_q  <= i_rx_data;
            state_q <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (i_rx_valid) begin
            aluB_q  <= i_rx_data;
            wdCnt_q <= '0;
            state_q <= WAIT_OP;
          end else if (wdExpire) begin
            wdCnt_q   <= '0;
            timeout_q <= 1'b1;
            state_q   <= WAIT_A;
          end else if (WD_ENABLE) begin
            wdCnt_q <= wdCnt_d;
          end
        end
        WAIT_OP: begin
          if (i_rx_valid) begin
            aluOp_q <= i_rx_data[NB_OP-1:0];
            wdCnt_q <= '0;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end else if (wdExpire) begin
            wdCnt_q   <= '0;
            timeout_q <= 1'b1;
            state_q   <= WAIT_A;
          end else if (WD_ENABLE) begin
            wdCnt_q <= wdCnt_d;
          end
        end
        // The ALU has had one full cycle on the registered operands by now.
        EXEC: begin
          wdCnt_q   <= '0;
          txData_q  <= i_alu_result;
          txStart_q <= 1'b1;
          drop_q    <= i_rx_valid;
          state_q   <= WAIT_TX;
        end
        WAIT_TX: begin
          wdCnt_q <= '0;
          drop_q  <= i_rx_valid;
          if (i_tx_done) begin
            busy_q  <= 1'b0;
            state_q <= WAIT_A;
          end
        end
        default: begin
          wdCnt_q <= '0;
          busy_q  <= 1'b0;
          state_q <= WAIT_A;
        end
      endcase
    end
  end

  assign o_alu_a    = aluA_q;
  assign o_alu_b    = aluB_q;
  assign o_alu_op   = aluOp_q;
  assign o_tx_data  = txData_q;
  assign o_tx_start = txStart_q;
  assign o_busy     = busy_q;
  assign o_timeout  = timeout_q;
  assign o_drop     = drop_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl: frames push expected results, a negedge
// monitor pops and compares whenever a transmission starts.
module tb_uart_alu_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic [7:0] i_alu_result;
  logic       i_tx_done;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [5:0] o_alu_op;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       o_busy;
  logic       o_timeout;
  logic       o_drop;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
  } exp_t;

  exp_t expQ[$];
  int   expTx = 0, seenTx = 0;
  int   expTimeouts = 0, seenTimeouts = 0;
  int   expDrops = 0, seenDrops = 0;
  logic [7:0] lastA = 8'h00, lastB = 8'h00;
  logic [5:0] lastOp = 6'h00;

  always #5 i_clk = ~i_clk;

  uart_alu_ctrl #(
    .NB_DATA(8),
    .NB_OP(6),
    .TIMEOUT_CYCLES(16),
    .NB_TIMEOUT(5)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_rx_data(i_rx_data),
    .i_rx_valid(i_rx_valid),
    .i_alu_result(i_alu_result),
    .i_tx_done(i_tx_done),
    .o_alu_a(o_alu_a),
    .o_alu_b(o_alu_b),
    .o_alu_op(o_alu_op),
    .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start),
    .o_busy(o_busy),
    .o_timeout(o_timeout),
    .o_drop(o_drop)
  );

  // Behavioural ALU: a small MIPS-like function table.
  function automatic logic [7:0] aluModel(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  always_comb i_alu_result = aluModel(o_alu_a, o_alu_b, o_alu_op);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: compares each transmission launch against the oldest expected frame.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_tx_start) begin
        seenTx++;
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_tx_start: got tx_data 0x%0h, expected no launch", o_tx_data);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("sb_tx_data", 32'(o_tx_data), 32'(e.res));
          checkOutput("sb_alu_a", 32'(o_alu_a), 32'(e.a));
          checkOutput("sb_alu_b", 32'(o_alu_b), 32'(e.b));
          checkOutput("sb_alu_op", 32'(o_alu_op), 32'(e.op));
          checkOutput("sb_busy", 32'(o_busy), 32'd1);
        end
      end
      if (o_timeout) seenTimeouts++;
      if (o_drop) seenDrops++;
    end
  end

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    i_rx_valid = 1'b1;
    i_rx_data  = data;
    idleCycles(1);
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
  endtask

  task automatic pushExp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opByte);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.op  = opByte[5:0];
    e.res = aluModel(a, b, opByte[5:0]);
    expQ.push_back(e);
    expTx++;
    lastA  = a;
    lastB  = b;
    lastOp = opByte[5:0];
  endtask

  task automatic sendFrame(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] opByte, input int gap);
    pushExp(a, b, opByte);
    applyStimulus(a);
    idleCycles(gap);
    applyStimulus(b);
    idleCycles(gap);
    applyStimulus(opByte);
  endtask

  task automatic pulseDone();
    i_tx_done = 1'b1;
    idleCycles(1);
    i_tx_done = 1'b0;
  endtask

  // Called right after the opcode byte was accepted; finishes the transmission.
  task automatic waitTxDone(input int delay, input bit doDrop);
    idleCycles(1);
    checkOutput("busy_wait_tx", 32'(o_busy), 32'd1);
    if (doDrop) begin
      applyStimulus(8'hAA);
      expDrops++;
      checkOutput("drop_pulse", 32'(o_drop), 32'd1);
      checkOutput("drop_keeps_a", 32'(o_alu_a), 32'(lastA));
      checkOutput("drop_keeps_b", 32'(o_alu_b), 32'(lastB));
      checkOutput("drop_keeps_op", 32'(o_alu_op), 32'(lastOp));
    end
    idleCycles(delay);
    pulseDone();
    checkOutput("busy_after_done", 32'(o_busy), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_alu_a"}, 32'(o_alu_a), 32'd0);
    checkOutput({tag, "_alu_b"}, 32'(o_alu_b), 32'd0);
    checkOutput({tag, "_alu_op"}, 32'(o_alu_op), 32'd0);
    checkOutput({tag, "_tx_data"}, 32'(o_tx_data), 32'd0);
    checkOutput({tag, "_tx_start"}, 32'(o_tx_start), 32'd0);
    checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
    checkOutput({tag, "_timeout"}, 32'(o_timeout), 32'd0);
    checkOutput({tag, "_drop"}, 32'(o_drop), 32'd0);
  endtask

  // Main stimulus sequence: directed scenarios first, then random frames.
  initial begin
    i_reset    = 1'b1;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    i_tx_done  = 1'b0;
    idleCycles(2);
    checkAllZero("reset");
    i_reset = 1'b0;
    idleCycles(1);

    sendFrame(8'h05, 8'h03, 8'h20, 1);
    checkOutput("basic_op_n1", 32'(o_alu_op), 32'h20);
    checkOutput("basic_start_n1", 32'(o_tx_start), 32'd0);
    idleCycles(1);
    checkOutput("basic_start_n2", 32'(o_tx_start), 32'd1);
    checkOutput("basic_data_n2", 32'(o_tx_data), 32'h08);
    idleCycles(1);
    checkOutput("basic_start_n3", 32'(o_tx_start), 32'd0);
    checkOutput("basic_busy_n3", 32'(o_busy), 32'd1);
    idleCycles(2);
    pulseDone();
    checkOutput("basic_busy_done", 32'(o_busy), 32'd0);
    checkOutput("basic_data_hold", 32'(o_tx_data), 32'h08);

    sendFrame(8'hFF, 8'h01, 8'h20, 0);
    waitTxDone(1, 1'b0);
    checkOutput("b2b_wrap_data", 32'(o_tx_data), 32'h00);

    applyStimulus(8'h11);
    idleCycles(15);
    checkOutput("wd_no_early", 32'(o_timeout), 32'd0);
    idleCycles(1);
    checkOutput("wd_timeout", 32'(o_timeout), 32'd1);
    expTimeouts++;
    applyStimulus(8'h22);
    checkOutput("wd_restart_a", 32'(o_alu_a), 32'h22);
    checkOutput("wd_b_unchanged", 32'(o_alu_b), 32'h01);
    idleCycles(15);
    pushExp(8'h22, 8'h44, 8'h25);
    applyStimulus(8'h44);
    checkOutput("wd_limit_accept", 32'(o_alu_b), 32'h44);
    checkOutput("wd_limit_no_to", 32'(o_timeout), 32'd0);
    idleCycles(15);
    applyStimulus(8'h25);
    checkOutput("wd_op_accept", 32'(o_timeout), 32'd0);
    waitTxDone(0, 1'b0);

    sendFrame(8'h02, 8'h02, 8'h20, 2);
    waitTxDone(2, 1'b1);
    sendFrame(8'h02, 8'h02, 8'h20, 0);
    waitTxDone(0, 1'b0);
    checkOutput("drop_next_frame", 32'(o_tx_data), 32'h04);

    applyStimulus(8'h05);
    applyStimulus(8'h03);
    i_reset = 1'b1;
    idleCycles(1);
    i_reset = 1'b0;
    checkAllZero("midreset");
    sendFrame(8'h07, 8'h01, 8'h22, 1);
    waitTxDone(1, 1'b0);
    checkOutput("midreset_sub", 32'(o_tx_data), 32'h06);

    pulseDone();
    checkOutput("spur_a_busy", 32'(o_busy), 32'd0);
    checkOutput("spur_a_start", 32'(o_tx_start), 32'd0);
    pushExp(8'h10, 8'h20, 8'h20);
    applyStimulus(8'h10);
    pulseDone();
    checkOutput("spur_b_busy", 32'(o_busy), 32'd0);
    checkOutput("spur_b_alu_a", 32'(o_alu_a), 32'h10);
    applyStimulus(8'h20);
    applyStimulus(8'h20);
    waitTxDone(1, 1'b0);
    checkOutput("spur_result", 32'(o_tx_data), 32'h30);

    for (int i = 0; i < 30; i++) begin
      logic [7:0] ra, rb, rop;
      int opSel;
      if ($urandom_range(5) == 0) begin
        applyStimulus(8'($urandom));
        idleCycles(16);
        checkOutput("rnd_timeout", 32'(o_timeout), 32'd1);
        expTimeouts++;
      end
      ra = 8'($urandom);
      rb = 8'($urandom);
      opSel = int'($urandom_range(5));
      rop = {2'($urandom), 6'h20 + 6'(opSel == 0 ? 0 : opSel + 1)};
      sendFrame(ra, rb, rop, int'($urandom_range(3)));
      waitTxDone(int'($urandom_range(3)), 1'($urandom));
    end

    idleCycles(3);
    checkOutput("sb_queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("tx_launch_count", 32'(seenTx), 32'(expTx));
    checkOutput("timeout_count", 32'(seenTimeouts), 32'(expTimeouts));
    checkOutput("drop_count", 32'(seenDrops), 32'(expDrops));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
